pipe_stage_skid: RTL and testbench

- Parametrised inter-stage pipeline register, the successor to the fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the ad-hoc stall input with a valid/ready handshake, and adds a synchronous flush.
- Uses a 2-entry skid buffer so neither side sees a combinational ready path, while throughput stays at one transfer per cycle.
- Separates the payload into data bits, which are held on a bubble, and control bits, which are forced to a safe bubble value.

---
 rtl/pipe_stage_skid.sv | 137 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised inter-stage pipeline register with a
// valid/ready handshake, synchronous flush and an optional 2-entry skid
// buffer. Data bits are held on a bubble; control bits are forced to
// CTRL_BUBBLE whenever no valid entry is presented.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter bit                SKID        = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              flush_c_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  bp_cycles_o
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]   bp_q, bp_d;

  logic accept;
  logic retire;

  // Outputs come straight from registers; in SKID mode ready depends only on state.
  always_comb begin
    out_valid_o = (state_q != ST_EMPTY);
    out_data_o  = head_data_q;
    out_ctrl_o  = head_ctrl_q;
    occupancy_o = state_q;
    bp_cycles_o = bp_q;
    if (SKID) begin
      in_ready_o = (state_q != ST_TWO);
    end else begin
      in_ready_o = ~out_valid_o | out_ready_i;
    end
    accept = in_valid_i & in_ready_o;
    retire = out_valid_o & out_ready_i;
  end

  // Next-state, payload movement, flush override and backpressure counter.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    bp_d        = bp_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          head_data_d = in_data_i;
          head_ctrl_d = in_ctrl_i;
        end
      end
      ST_ONE: begin
        if (accept && retire) begin
          head_data_d = in_data_i;
          head_ctrl_d = in_ctrl_i;
        end else if (accept && SKID) begin
          state_d     = ST_TWO;
          skid_data_d = in_data_i;
          skid_ctrl_d = in_ctrl_i;
        end else if (retire) begin
          state_d     = ST_EMPTY;
          head_ctrl_d = CTRL_BUBBLE;
        end
      end
      ST_TWO: begin
        if (retire) begin
          state_d     = ST_ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
          skid_ctrl_d = CTRL_BUBBLE;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        head_ctrl_d = CTRL_BUBBLE;
        skid_ctrl_d = CTRL_BUBBLE;
      end
    endcase

    // Flush kills every held entry; data is left in place, only control is scrubbed.
    if (flush_c_i) begin
      state_d     = ST_EMPTY;
      head_ctrl_d = CTRL_BUBBLE;
      skid_ctrl_d = CTRL_BUBBLE;
    end

    // Stall counter saturates at all-ones and survives a flush.
    if (out_valid_o && !out_ready_i && (bp_q != {CNT_W{1'b1}})) begin
      bp_d = bp_q + CNT_W'(1);
    end
  end

  // State and payload registers with asynchronous active-low reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      bp_q        <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      bp_q        <= bp_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of pipe_stage_skid in three builds:
// default skid stage, a 4-bit counter skid stage and a SKID=0 stage.
module tb_pipe_stage_skid;

  logic ACLK;
  logic ARESETn;

  // Main instance (SKID=1, CNT_W=16)
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [1:0]  occ;
  logic [15:0] bp;

  // Saturation instance (SKID=1, CNT_W=4)
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [63:0] s_in_data, s_out_data;
  logic [7:0]  s_in_ctrl, s_out_ctrl;
  logic [1:0]  s_occ;
  logic [3:0]  s_bp;

  // Single-register instance (SKID=0)
  logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [63:0] z_in_data, z_out_data;
  logic [7:0]  z_in_ctrl, z_out_ctrl;
  logic [1:0]  z_occ;
  logic [15:0] z_bp;

  int checks = 0;
  int passed = 0;

  pipe_stage_skid dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .flush_c_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ctrl_o(out_ctrl),
    .occupancy_o(occ), .bp_cycles_o(bp)
  );

  pipe_stage_skid #(.CNT_W(4)) dut_sat (
    .ACLK(ACLK), .ARESETn(ARESETn), .flush_c_i(s_flush),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .in_data_i(s_in_data), .in_ctrl_i(s_in_ctrl),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .out_data_o(s_out_data), .out_ctrl_o(s_out_ctrl),
    .occupancy_o(s_occ), .bp_cycles_o(s_bp)
  );

  pipe_stage_skid #(.SKID(1'b0)) dut_z (
    .ACLK(ACLK), .ARESETn(ARESETn), .flush_c_i(z_flush),
    .in_valid_i(z_in_valid), .in_ready_o(z_in_ready),
    .in_data_i(z_in_data), .in_ctrl_i(z_in_ctrl),
    .out_valid_o(z_out_valid), .out_ready_i(z_out_ready),
    .out_data_o(z_out_data), .out_ctrl_o(z_out_ctrl),
    .occupancy_o(z_occ), .bp_cycles_o(z_bp)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (occ !== 2'd0) $display("[TB] FAIL reset_occ: got %0d expected 0", occ); else passed++;
    checks++; if (bp !== 16'd0) $display("[TB] FAIL reset_bp: got %0d expected 0", bp); else passed++;
    checks++; if (out_data !== 64'd0) $display("[TB] FAIL reset_data: got %h expected 0", out_data); else passed++;
    checks++; if (out_ctrl !== 8'h00) $display("[TB] FAIL reset_ctrl: got %h expected 00", out_ctrl); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %0b expected 1", in_ready); else passed++;
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %0b expected 1", in_ready); else passed++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'd1;
    in_ctrl   = 8'd1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL stream_pre_valid: got %0b expected 0", out_valid); else passed++;
    for (int i = 1; i <= 8; i++) begin
      in_data = 64'(i);
      in_ctrl = 8'(i);
      tick();
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %0b expected 1", i, out_valid); else passed++;
      checks++; if (out_data !== 64'(i)) $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, out_data, 64'(i)); else passed++;
      checks++; if (out_ctrl !== 8'(i)) $display("[TB] FAIL stream_ctrl[%0d]: got %h expected %h", i, out_ctrl, 8'(i)); else passed++;
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL stream_ready[%0d]: got %0b expected 1", i, in_ready); else passed++;
      checks++; if (occ !== 2'd1) $display("[TB] FAIL stream_occ[%0d]: got %0d expected 1", i, occ); else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occ !== 2'd0) $display("[TB] FAIL stream_drain_occ: got %0d expected 0", occ); else passed++;
    checks++; if (out_ctrl !== 8'h00) $display("[TB] FAIL stream_drain_ctrl: got %h expected 00", out_ctrl); else passed++;
    checks++; if (bp !== 16'd0) $display("[TB] FAIL stream_bp: got %0d expected 0", bp); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    in_ctrl   = 8'h0A;
    tick();
    checks++; if (occ !== 2'd1) $display("[TB] FAIL bp_occ1: got %0d expected 1", occ); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready1: got %0b expected 1", in_ready); else passed++;
    in_data = 64'hB;
    in_ctrl = 8'h0B;
    tick();
    checks++; if (occ !== 2'd2) $display("[TB] FAIL bp_occ2: got %0d expected 2", occ); else passed++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready2: got %0b expected 0", in_ready); else passed++;
    checks++; if (out_data !== 64'hA) $display("[TB] FAIL bp_head: got %h expected a", out_data); else passed++;
    checks++; if (bp !== 16'd1) $display("[TB] FAIL bp_cnt1: got %0d expected 1", bp); else passed++;
    in_valid = 1'b0;
    tick();
    checks++; if (occ !== 2'd2) $display("[TB] FAIL bp_hold_occ: got %0d expected 2", occ); else passed++;
    checks++; if (out_data !== 64'hA) $display("[TB] FAIL bp_hold_data: got %h expected a", out_data); else passed++;
    checks++; if (bp !== 16'd2) $display("[TB] FAIL bp_cnt2: got %0d expected 2", bp); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 64'hB) $display("[TB] FAIL bp_order: got %h expected b", out_data); else passed++;
    checks++; if (out_ctrl !== 8'h0B) $display("[TB] FAIL bp_order_ctrl: got %h expected 0b", out_ctrl); else passed++;
    checks++; if (occ !== 2'd1) $display("[TB] FAIL bp_occ_after: got %0d expected 1", occ); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_after: got %0b expected 1", in_ready); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_empty_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 64'hB) $display("[TB] FAIL bp_empty_data: got %h expected b", out_data); else passed++;
    checks++; if (bp !== 16'd2) $display("[TB] FAIL bp_cnt_final: got %0d expected 2", bp); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    in_ctrl   = 8'h81;
    tick();
    in_data = 64'h12;
    in_ctrl = 8'h82;
    tick();
    checks++; if (occ !== 2'd2) $display("[TB] FAIL flush_setup_occ: got %0d expected 2", occ); else passed++;
    flush   = 1'b1;
    in_data = 64'hC;
    in_ctrl = 8'hCC;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (occ !== 2'd0) $display("[TB] FAIL flush_occ: got %0d expected 0", occ); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (out_ctrl !== 8'h00) $display("[TB] FAIL flush_ctrl: got %h expected 00", out_ctrl); else passed++;
    checks++; if (out_data !== 64'h11) $display("[TB] FAIL flush_data_held: got %h expected 11", out_data); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %0b expected 1", in_ready); else passed++;
    checks++; if (bp !== 16'd4) $display("[TB] FAIL flush_bp: got %0d expected 4", bp); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_no_emit[%0d]: got %0b expected 0", i, out_valid); else passed++;
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'hD;
    in_ctrl  = 8'hDD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_accept_dropped: got %0b expected 0", out_valid); else passed++;
    tick();
    checks++; if (occ !== 2'd0) $display("[TB] FAIL flush_accept_occ: got %0d expected 0", occ); else passed++;
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h5A5A;
    in_ctrl   = 8'hFF;
    tick();
    in_valid = 1'b0;
    checks++; if (out_ctrl !== 8'hFF) $display("[TB] FAIL bubble_ctrl_live: got %h expected ff", out_ctrl); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bubble_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (out_ctrl !== 8'h00) $display("[TB] FAIL bubble_ctrl: got %h expected 00", out_ctrl); else passed++;
    checks++; if (out_data !== 64'h5A5A) $display("[TB] FAIL bubble_data: got %h expected 5a5a", out_data); else passed++;
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 64'h77;
    s_in_ctrl   = 8'h07;
    tick();
    s_in_valid = 1'b0;
    checks++; if (s_bp !== 4'd0) $display("[TB] FAIL sat_start: got %0d expected 0", s_bp); else passed++;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10 || k == 15 || k == 20) begin
        checks++;
        if (s_bp !== ((k > 15) ? 4'd15 : 4'(k)))
          $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", k, s_bp, (k > 15) ? 15 : k);
        else passed++;
      end
    end
    checks++; if (s_out_valid !== 1'b1) $display("[TB] FAIL sat_valid: got %0b expected 1", s_out_valid); else passed++;
  endtask

  task automatic test_no_skid();
    z_out_ready = 1'b0;
    z_in_valid  = 1'b1;
    z_in_data   = 64'h21;
    z_in_ctrl   = 8'h21;
    #1;
    checks++; if (z_in_ready !== 1'b1) $display("[TB] FAIL z_ready_empty: got %0b expected 1", z_in_ready); else passed++;
    tick();
    z_in_data = 64'h22;
    z_in_ctrl = 8'h22;
    #1;
    checks++; if (z_in_ready !== 1'b0) $display("[TB] FAIL z_ready_stall: got %0b expected 0", z_in_ready); else passed++;
    checks++; if (z_out_data !== 64'h21) $display("[TB] FAIL z_head: got %h expected 21", z_out_data); else passed++;
    z_out_ready = 1'b1;
    #1;
    checks++; if (z_in_ready !== 1'b1) $display("[TB] FAIL z_ready_comb: got %0b expected 1", z_in_ready); else passed++;
    tick();
    checks++; if (z_occ !== 2'd1) $display("[TB] FAIL z_occ_pass: got %0d expected 1", z_occ); else passed++;
    checks++; if (z_out_data !== 64'h22) $display("[TB] FAIL z_data_pass: got %h expected 22", z_out_data); else passed++;
    z_out_ready = 1'b0;
    z_in_data   = 64'h23;
    z_in_ctrl   = 8'h23;
    tick();
    checks++; if (z_occ !== 2'd1) $display("[TB] FAIL z_occ_hold: got %0d expected 1", z_occ); else passed++;
    checks++; if (z_out_data !== 64'h22) $display("[TB] FAIL z_data_hold: got %h expected 22", z_out_data); else passed++;
    z_in_valid  = 1'b0;
    z_out_ready = 1'b1;
    tick();
    checks++; if (z_occ !== 2'd0) $display("[TB] FAIL z_drain_occ: got %0d expected 0", z_occ); else passed++;
    checks++; if (z_out_ctrl !== 8'h00) $display("[TB] FAIL z_drain_ctrl: got %h expected 00", z_out_ctrl); else passed++;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h31;
    in_ctrl   = 8'h31;
    tick();
    in_data = 64'h32;
    in_ctrl = 8'h32;
    tick();
    in_valid = 1'b0;
    checks++; if (occ !== 2'd2) $display("[TB] FAIL mr_setup_occ: got %0d expected 2", occ); else passed++;
    #2;
    ARESETn = 1'b0;
    #1;
    checks++; if (occ !== 2'd0) $display("[TB] FAIL mr_occ: got %0d expected 0", occ); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mr_valid: got %0b expected 0", out_valid); else passed++;
    checks++; if (out_data !== 64'd0) $display("[TB] FAIL mr_data: got %h expected 0", out_data); else passed++;
    checks++; if (out_ctrl !== 8'h00) $display("[TB] FAIL mr_ctrl: got %h expected 00", out_ctrl); else passed++;
    checks++; if (bp !== 16'd0) $display("[TB] FAIL mr_bp: got %0d expected 0", bp); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mr_ready: got %0b expected 1", in_ready); else passed++;
    @(negedge ACLK);
    ARESETn   = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mr_after_valid: got %0b expected 0", out_valid); else passed++;
  endtask

  // Test sequence
  initial begin
    ARESETn = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0; s_in_ctrl = '0;
    z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_data = '0; z_in_ctrl = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_no_skid();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
